lcd_bus_sequencer: RTL and testbench
====================================

LCD_BUS_SEQUENCER -- requirements
Module: lcd_bus_sequencer

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- T_SETUP_CYC, 4: clocks RS/data are stable before E rises.
- T_EN_CYC, 12: clocks E is held high.
- T_HOLD_CYC, 2: clocks RS/data are held after E falls.
- T_EXEC_CYC, 2000: post-write wait for short commands and data.
- T_LONG_CYC, 82000: post-write wait for clear/home.
REQ-002 All T_* parameters SHALL be in the range 1 to 2^20-1; the counter is 20 bits wide.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- reset_n, in, 1: reset, asynchronous and active-low.
- cmd_word, in, 12: registered PIO word; [7:0] data, [8] RS, [9] overflow clear, [10] strobe (toggle), [11] backlight.
- lcd_data, out, 8: HD44780 DB7..DB0.
- lcd_rs, out, 1: register select.
- lcd_rw, out, 1: read/write, tied 0 (write only).
- lcd_en, out, 1: enable strobe.
- lcd_on, out, 1: backlight/power.
- busy, out, 1: high when state is not IDLE or the queue is non-empty.
- overflow, out, 1: sticky flag for a dropped request.

Function
REQ-004 A request SHALL be any change of cmd_word[10] relative to its value registered on the previous clock.
- On a request, {cmd_word[8], cmd_word[7:0]} is pushed on the next edge.
REQ-005 lcd_on SHALL be cmd_word[11], registered once, and SHALL not be queued.
REQ-006 The FSM SHALL have states IDLE, SETUP, PULSE, HOLD and EXEC.
REQ-007 IDLE with a non-empty queue SHALL pop the head on the next edge, load lcd_rs/lcd_data from it, and enter SETUP.
- With an empty queue and idle FSM, this edge is 2 clocks after the cmd_word toggle edge.
REQ-008 SETUP SHALL last T_SETUP_CYC clocks with lcd_en=0, then enter PULSE.
REQ-009 PULSE SHALL last T_EN_CYC clocks with lcd_en=1, then enter HOLD.
REQ-010 HOLD SHALL last T_HOLD_CYC clocks with lcd_en=0, then enter EXEC.
REQ-011 EXEC SHALL last T_LONG_CYC clocks if the entry is long, otherwise T_EXEC_CYC clocks, then enter IDLE.
- Long means RS=0 and data in {0x01, 0x02, 0x03}.
REQ-012 lcd_rs and lcd_data SHALL change only on the IDLE->SETUP edge and SHALL be held through EXEC and IDLE.
REQ-013 lcd_en SHALL be registered and glitch-free.
REQ-014 Consecutive queued entries SHALL start back-to-back: EXEC end -> IDLE for 1 clock -> SETUP.
REQ-015 A request arriving while the queue is full SHALL be dropped and set overflow.
- A push and a pop on the same edge with a full queue SHALL be accepted and SHALL NOT set overflow.
REQ-016 While cmd_word[9]=1, overflow SHALL be 0; clear takes priority over a simultaneous set.
REQ-017 Requests SHALL be accepted in every FSM state and SHALL be executed in arrival order.

Reset
REQ-018 Asserting reset_n low SHALL immediately force the following, regardless of the cycle in progress, including mid-PULSE:
- lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_on=0.
- busy=0, overflow=0.
- FSM=IDLE, queue empty, registered strobe=0, counter=0.
REQ-019 After release, a cmd_word[10]=1 on the first clock SHALL count as a request (0->1).

Configuration
REQ-020 The macro LCD_SEQ_FIFO_EN SHALL select the queue depth:
- Defined: the queue is a 4-entry FIFO.
- Undefined: the queue is a single holding register; a request while it is occupied is dropped per REQ-015.
- In both cases, REQ-015 same-edge pop/push acceptance SHALL hold.

Verification
REQ-021 The bench SHALL cover these directed scenarios (defaults, T_EXEC_CYC=20, T_LONG_CYC=50 for bench):
- Single write: toggle with RS=1, data=0x41 -> lcd_data=0x41 and lcd_rs=1 2 clocks later; lcd_en high for exactly 12 clocks starting 4 clocks after; busy low 1+4+12+2+20 clocks after the load edge.
- Long command: RS=0, data=0x01 -> EXEC lasts 50 clocks; the same sequence with data=0x04 -> EXEC lasts 20 clocks.
- Burst with LCD_SEQ_FIFO_EN defined: 6 toggles on consecutive clocks -> 0x30..0x34 executed in order, 6th dropped, overflow=1; then cmd_word[9]=1 -> overflow=0 next clock.
- Burst without the macro: 2 toggles back-to-back -> both execute (second is held while the first runs); a 3rd during the first's EXEC -> dropped, overflow=1.
- Reset mid-PULSE: reset_n low while lcd_en=1 -> lcd_en=0 and busy=0 with no clock edge; the queue is empty after release.
- Backlight: cmd_word[11] 0->1 with no toggle -> lcd_on=1 after 1 clock, nothing queued, busy=0.

Source files
------------

// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer: write-only HD44780 bus sequencer.
// A toggle of cmd_word[10] queues {RS, data}; the FSM replays each entry as
// SETUP -> PULSE (E high) -> HOLD -> EXEC wait, in arrival order.
// Build option: define LCD_SEQ_FIFO_EN for a 4-entry queue; otherwise the
// queue is a single holding register.
module lcd_bus_sequencer #(
  parameter int unsigned T_SETUP_CYC = 4,
  parameter int unsigned T_EN_CYC    = 12,
  parameter int unsigned T_HOLD_CYC  = 2,
  parameter int unsigned T_EXEC_CYC  = 2000,
  parameter int unsigned T_LONG_CYC  = 82000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] cmd_word,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on,
  output logic        busy,
  output logic        overflow
);

  // Counters are loaded with (length - 1) and count down to zero.
  localparam logic [19:0] SETUP_LD = 20'(T_SETUP_CYC - 1);
  localparam logic [19:0] EN_LD    = 20'(T_EN_CYC - 1);
  localparam logic [19:0] HOLD_LD  = 20'(T_HOLD_CYC - 1);
  localparam logic [19:0] EXEC_LD  = 20'(T_EXEC_CYC - 1);
  localparam logic [19:0] LONG_LD  = 20'(T_LONG_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        en_q, en_d;
  logic        on_q, on_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;
  logic        strobe_q, strobe_d;

  logic        req;
  logic        push;
  logic        pop;
  logic        ovf_set;
  logic        is_long;
  logic        q_empty;
  logic        q_full;
  logic [8:0]  q_head;
  logic [8:0]  q_in;

  assign req     = cmd_word[10] ^ strobe_q;
  assign q_in    = cmd_word[8:0];
  assign pop     = (state_q == S_IDLE) && !q_empty;
  // A full queue still accepts a request when the head leaves on the same edge.
  assign push    = req && (!q_full || pop);
  assign ovf_set = req && q_full && !pop;
  assign is_long = !rs_q && (data_q inside {8'h01, 8'h02, 8'h03});

`ifdef LCD_SEQ_FIFO_EN
  logic [8:0] mem_q [4];
  logic [8:0] mem_d [4];
  logic [1:0] rd_q, rd_d;
  logic [1:0] wr_q, wr_d;
  logic [2:0] fill_q, fill_d;

  assign q_empty = (fill_q == 3'd0);
  assign q_full  = (fill_q == 3'd4);
  assign q_head  = mem_q[rd_q];

  // Circular-buffer pointer and occupancy update.
  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    fill_d = fill_q;
    if (push) begin
      mem_d[wr_q] = q_in;
      wr_d        = wr_q + 2'd1;
    end
    if (pop) begin
      rd_d = rd_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   fill_d = fill_q + 3'd1;
      2'b01:   fill_d = fill_q - 3'd1;
      default: fill_d = fill_q;
    endcase
  end

  // Queue storage registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
      rd_q   <= '0;
      wr_q   <= '0;
      fill_q <= '0;
    end else begin
      mem_q  <= mem_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      fill_q <= fill_d;
    end
  end
`else
  logic [8:0] hold_q, hold_d;
  logic       valid_q, valid_d;

  assign q_empty = !valid_q;
  assign q_full  = valid_q;
  assign q_head  = hold_q;

  // Single holding register; a same-edge pop and push simply replaces it.
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d = 1'b0;
    end
    if (push) begin
      hold_d  = q_in;
      valid_d = 1'b1;
    end
  end

  // Holding register storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end
`endif

  // Next-state, counter and output computation for the bus FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    rs_d     = rs_q;
    en_d     = en_q;
    on_d     = cmd_word[11];
    strobe_d = cmd_word[10];
    busy_d   = (state_q != S_IDLE) || !q_empty;
    ovf_d    = ovf_q;
    if (cmd_word[9]) begin
      ovf_d = 1'b0;
    end else if (ovf_set) begin
      ovf_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (!q_empty) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          data_d  = q_head[7:0];
          rs_d    = q_head[8];
          en_d    = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = EN_LD;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_EXEC;
          cnt_d   = is_long ? LONG_LD : EXEC_LD;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        en_d    = 1'b0;
      end
    endcase
  end

  // FSM state and registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      on_q     <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rs_q     <= rs_d;
      en_q     <= en_d;
      on_q     <= on_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      strobe_q <= strobe_d;
    end
  end

  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_q;
  assign lcd_on   = on_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed self-checking bench for lcd_bus_sequencer (short EXEC=20, long EXEC=50).
module tb_lcd_bus_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] cmd_word;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        lcd_on;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] seen [$];
  logic       en_prev = 1'b0;

  lcd_bus_sequencer #(
    .T_SETUP_CYC(4),
    .T_EN_CYC   (12),
    .T_HOLD_CYC (2),
    .T_EXEC_CYC (20),
    .T_LONG_CYC (50)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cmd_word(cmd_word),
    .lcd_data(lcd_data),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_en  (lcd_en),
    .lcd_on  (lcd_on),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Record the data byte presented at every rising edge of E.
  always @(negedge clk) begin
    if (!en_prev && lcd_en) seen.push_back(lcd_data);
    en_prev = lcd_en;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle(input logic rs, input logic [7:0] d);
    cmd_word[10]  = ~cmd_word[10];
    cmd_word[8]   = rs;
    cmd_word[7:0] = d;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    tick(3);
    n = 0;
    while (busy && n < limit) begin
      tick(1);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // One write from an idle block; measures E window and busy release.
  task automatic run_one(input logic rs, input logic [7:0] d, input int exp_fall);
    int first_en, last_en, n_en, fall;
    logic held;
    tick(1);
    toggle(rs, d);
    tick(2);
    check("load_data", {24'd0, lcd_data}, {24'd0, d});
    check("load_rs", {31'd0, lcd_rs}, {31'd0, rs});
    check("load_en", {31'd0, lcd_en}, 32'd0);
    first_en = -1; last_en = -1; n_en = 0; fall = -1; held = 1'b1;
    for (int i = 1; i <= 200 && fall < 0; i++) begin
      tick(1);
      if (lcd_en) begin
        n_en++;
        if (first_en < 0) first_en = i;
        last_en = i;
      end
      if (lcd_data !== d || lcd_rs !== rs) held = 1'b0;
      if (!busy) fall = i;
    end
    check("en_start", first_en, 4);
    check("en_last", last_en, 15);
    check("en_len", n_en, 12);
    check("busy_fall", fall, exp_fall);
    check("bus_held", {31'd0, held}, 32'd1);
    check("rw_low", {31'd0, lcd_rw}, 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    cmd_word = '0;
    tick(2);
    check("rst_data", {24'd0, lcd_data}, 32'd0);
    check("rst_rs", {31'd0, lcd_rs}, 32'd0);
    check("rst_en", {31'd0, lcd_en}, 32'd0);
    check("rst_on", {31'd0, lcd_on}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;

    // Single data write, long command, short command.
    run_one(1'b1, 8'h41, 39);
    run_one(1'b0, 8'h01, 69);
    run_one(1'b0, 8'h04, 39);

`ifdef LCD_SEQ_FIFO_EN
    // Six requests on consecutive clocks: five fit, the sixth is dropped.
    seen.delete();
    for (int k = 0; k < 6; k++) begin
      tick(1);
      toggle(1'b1, 8'h30 + 8'(k));
    end
    wait_idle(400);
    check("burst_cnt", seen.size(), 5);
    for (int k = 0; k < 5; k++) begin
      check("burst_order", {24'd0, seen[k]}, 32'h30 + 32'(k));
    end
    check("burst_ovf", {31'd0, overflow}, 32'd1);
`else
    // Two back-to-back requests both run; a third during EXEC is dropped.
    seen.delete();
    tick(1);
    toggle(1'b1, 8'h50);
    tick(1);
    toggle(1'b1, 8'h51);
    for (int c = 0; c < 130; c++) begin
      tick(1);
      if (c == 24) check("pair_no_ovf", {31'd0, overflow}, 32'd0);
      if (c == 25) toggle(1'b1, 8'h52);
      if (c == 27) check("drop_ovf", {31'd0, overflow}, 32'd1);
    end
    check("pair_cnt", seen.size(), 2);
    check("pair_first", {24'd0, seen[0]}, 32'h50);
    check("pair_second", {24'd0, seen[1]}, 32'h51);
    check("pair_idle", {31'd0, busy}, 32'd0);
`endif
    cmd_word[9] = 1'b1;
    tick(1);
    check("ovf_clear", {31'd0, overflow}, 32'd0);
    cmd_word[9] = 1'b0;
    tick(1);
    check("ovf_stays", {31'd0, overflow}, 32'd0);

    // Backlight bit is registered directly and queues nothing.
    seen.delete();
    cmd_word[11] = 1'b1;
    check("on_before", {31'd0, lcd_on}, 32'd0);
    tick(1);
    check("on_after", {31'd0, lcd_on}, 32'd1);
    tick(3);
    check("on_busy", {31'd0, busy}, 32'd0);
    check("on_noq", seen.size(), 0);

    // Asynchronous reset in the middle of the E pulse, with one entry queued.
    tick(1);
    toggle(1'b1, 8'h60);
    tick(1);
    toggle(1'b1, 8'h61);
    tick(7);
    check("pre_rst_en", {31'd0, lcd_en}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_en", {31'd0, lcd_en}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_data", {24'd0, lcd_data}, 32'd0);
    check("arst_rs", {31'd0, lcd_rs}, 32'd0);
    check("arst_on", {31'd0, lcd_on}, 32'd0);
    cmd_word = '0;
    tick(2);
    reset_n = 1'b1;
    seen.delete();
    tick(60);
    check("post_rst_noq", seen.size(), 0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_data", {24'd0, lcd_data}, 32'd0);

    // Strobe already high on the first clock after release is a request.
    reset_n = 1'b0;
    cmd_word = 12'h000;
    cmd_word[10] = 1'b1;
    cmd_word[8] = 1'b1;
    cmd_word[7:0] = 8'h5A;
    tick(1);
    reset_n = 1'b1;
    tick(2);
    check("rel_req_data", {24'd0, lcd_data}, 32'h5A);
    check("rel_req_rs", {31'd0, lcd_rs}, 32'd1);
    wait_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
